wb_port_arbiter8: RTL
=====================

# wb_port_arbiter8

Round-robin arbiter that shares one write-back port among up to eight requesters, such as functional units or load/store paths. It issues a registered 3-bit grant index and its one-hot decode, so the winning unit drives the port and its select line directly. The grant is held until the owner releases it. With the timeout compiled in, the grant is also revoked after a bounded hold time. Arbitration is fair: after every grant, priority rotates to the index after the last winner.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced release. Legal range 1..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, 8: `req[i]` high means requester i wants the port. It stays high for as long as the requester uses the port.
- `grant_valid`, output, 1: a grant is active.
- `grant_idx`, output, 3: index of the current owner. Reads 0 when `grant_valid` is low.
- `grant`, output, 8: one-hot decode of `grant_idx` while `grant_valid` is high, otherwise 8'h00.
- `timeout`, output, 1: one-cycle pulse on a forced release. Tied to 0 when `ARB_TIMEOUT_EN` is undefined.

## Operation
- Two states: IDLE and BUSY. All outputs and `ptr` (3-bit priority pointer) are registers.
- Reset value (async, while `rst_n`=0):
  - state IDLE
  - `ptr`=0
  - `grant_valid`=0, `grant_idx`=0, `grant`=8'h00
  - `timeout`=0
  - hold counter 0
- IDLE, `req`==0: stay IDLE; outputs unchanged at 0.
- IDLE, `req`!=0:
  - Select the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … , `ptr`+7 (mod 8).
  - Load `grant_idx`=i, `grant`=1<<i, `grant_valid`=1.
  - Set `ptr`=(i+1) mod 8; 7 wraps to 0.
  - Clear the hold counter and go to BUSY.
- BUSY, `req[grant_idx]`=1 and no timeout: hold all grant outputs; hold counter +1, saturating.
- BUSY, `req[grant_idx]`=0 (release): clear `grant_valid`, `grant`, `grant_idx`; go to IDLE.
- Requests from non-owners are ignored in BUSY. They are only evaluated in IDLE.
- Only the owner's `req` bit is observed in BUSY. Other `req` bits changing have no effect on it.
- The one-hot invariant holds in every cycle: `grant` == (`grant_valid` ? 1<<`grant_idx` : 0).

## Timing
- Grant latency: `req` sampled high at edge N while IDLE gives the grant visible after edge N (one cycle).
- Release: owner `req` sampled low at edge M drops the grant after edge M. The next arbitration happens at edge M+1.
- There is always exactly one idle cycle between successive grants. Peak port utilisation is one grant per (hold + 1) cycles.
- Simultaneous owner release and a new request at the same edge: the release wins. The new request is arbitrated at the next edge.
- A requester that drops `req` before being granted is simply not selected. There is no latching of requests.
- Async reset mid-grant: all outputs return to 0 immediately, without waiting for a clock edge. After deassertion, arbitration restarts with `ptr`=0.
- Reset deassertion: the first arbitration occurs at the first rising edge with `rst_n`=1.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter of width clog2(`MAX_HOLD`+1) counts BUSY cycles, starting at 1 on the grant cycle.
  - In the cycle where the counter equals `MAX_HOLD` and owner `req` is still high, the next edge drops the grant, goes to IDLE and pulses `timeout` for one cycle.
  - `ptr` is already past the owner, so other pending requesters win first. The same owner may be regranted after the idle cycle if it is the only requester.
- Undefined: no counter and no forced release; the grant is held indefinitely; `timeout` is constant 0.

## Test plan
- Reset: assert `rst_n`=0 with `req`=8'hFF → `grant`=8'h00, `grant_valid`=0, `grant_idx`=0, `timeout`=0. After release of reset, the first grant is idx 0.
- Priority and rotation: from reset, `req`=8'h81 → grant idx 0 (`grant`=8'h01). Owner drops `req[0]` → one idle cycle, then idx 7 (`grant`=8'h80). Then `req`=8'h81 again → idx 0.
- Wrap-around: hold `req`=8'hFF and release each grant after 2 cycles → grant order 0,1,2,…,7,0,1. Exactly one idle cycle between grants; `grant` is always one-hot.
- Non-owner ignored: grant idx 2, then raise `req[1]` and `req[5]` → `grant` stays 8'h04 until `req[2]` drops. Next grant is idx 5, then idx 1.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=16):
  - `req`=8'h08 held high → `grant`=8'h08 for exactly 16 cycles, then a `timeout` pulse and 1 idle cycle, then a regrant to idx 3.
  - With `req`=8'h48, the grant after the idx 3 timeout goes to idx 6.
- Reset mid-grant: while `grant`=8'h10, pull `rst_n` low between clock edges → outputs are 0 before the next edge. After reset with `req`=8'h30, the grant goes to idx 4 because `ptr` is back at 0.

Source files
------------

// File: rtl/wb_port_arbiter8.sv
// Purpose : round-robin owner arbiter for one shared write-back port, eight requesters.
// Latency : a request sampled in IDLE is granted one cycle later; a release drops the grant one cycle later.
// Backpress: no stall path; the owner holds the port while its req stays high, and all other requesters wait.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[7:0]     per-requester port request, held high while the port is in use
//   grant_valid  a grant is active
//   grant_idx    index of the current owner (0 when no grant)
//   grant[7:0]   one-hot select of the owner (8'h00 when no grant)
//   timeout      one-cycle pulse after a forced release
//
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a grant is revoked after
// MAX_HOLD consecutive cycles. When undefined, a grant is held until the owner
// releases it, and timeout is tied low.

module wb_port_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant,
    output logic       timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("wb_port_arbiter8: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic       grant_valid_nxt;
    logic [2:0] grant_idx_nxt;
    logic [7:0] grant_nxt;
    logic [2:0] win_idx;
    logic [2:0] cand;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_nxt;
    logic          timeout_q;
    logic          timeout_nxt;
    logic          hold_expired;

    // hold_cnt reads 1 in the first granted cycle, so the grant stays visible for
    // exactly MAX_HOLD cycles before the forced release.
    assign hold_expired = (hold_cnt == CW'(MAX_HOLD));
    assign timeout      = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Round-robin pick: scan ptr, ptr+1, ... , ptr+7 (mod 8). The scan runs from
    // the farthest offset down, so the nearest requesting index is written last and wins.
    always_comb begin
        win_idx = 3'd0;
        cand    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_valid_nxt = grant_valid;
        grant_idx_nxt   = grant_idx;
        grant_nxt       = grant;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt    = hold_cnt;
        timeout_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt       = BUSY;
                    grant_valid_nxt = 1'b1;
                    grant_idx_nxt   = win_idx;
                    grant_nxt       = 8'd1 << win_idx;
                    // The pointer moves past the winner so it has lowest priority next time.
                    ptr_nxt         = win_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt    = CW'(1);
`endif
                end
            end
            BUSY: begin
                // Only the owner's bit is observed here; other requesters wait for IDLE.
                if (!req[grant_idx]) begin
                    state_nxt       = IDLE;
                    grant_valid_nxt = 1'b0;
                    grant_idx_nxt   = 3'd0;
                    grant_nxt       = 8'h00;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt    = '0;
                end else if (hold_expired) begin
                    state_nxt       = IDLE;
                    grant_valid_nxt = 1'b0;
                    grant_idx_nxt   = 3'd0;
                    grant_nxt       = 8'h00;
                    hold_cnt_nxt    = '0;
                    timeout_nxt     = 1'b1;
                end else if (hold_cnt != {CW{1'b1}}) begin
                    hold_cnt_nxt    = hold_cnt + CW'(1);
`endif
                end
            end
            default: begin
                state_nxt       = IDLE;
                grant_valid_nxt = 1'b0;
                grant_idx_nxt   = 3'd0;
                grant_nxt       = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            grant_valid <= 1'b0;
            grant_idx   <= 3'd0;
            grant       <= 8'h00;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_valid <= grant_valid_nxt;
            grant_idx   <= grant_idx_nxt;
            grant       <= grant_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end
`endif

endmodule
